// File: rtl/calc_pkg.sv
// Shared types and constants for the board calculator sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CONV,
    SHOW
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int MAG_W = 10;
  localparam int OPND_W = 5;

  function automatic logic [BCD_W-1:0] dabble_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Board-side bundle: switches and keys in, result and digit codes out.
interface calc_sequencer_if;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] RESULT;
  logic       NEG;
  logic [3:0] DIG0;
  logic [3:0] DIG1;
  logic [3:0] DIG2;
  logic [3:0] DIG3;
  logic [1:0] OP;
  logic       BUSY;
  logic       DONE;

  modport master (
    output SW, KEY,
    input  RESULT, NEG, DIG0, DIG1, DIG2, DIG3, OP, BUSY, DONE
  );

  modport slave (
    input  SW, KEY,
    output RESULT, NEG, DIG0, DIG1, DIG2, DIG3, OP, BUSY, DONE
  );
endinterface

// File: rtl/key_debounce.sv
// Active-low key: 2-flop sync, saturating low-time counter, press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          prs_q;
  logic          pressed;

  assign pressed = (cnt_q == CW'(DEB_CYCLES));
  assign press_o = pressed & ~prs_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) cnt_d = '0;
    else if (!pressed) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      prs_q   <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      prs_q   <= pressed;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: key events, add/sub/shift-add multiply,
// iterative double-dabble, registered sign-magnitude and BCD outputs.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input logic            CLOCK_50,
  input logic            RESET,
  calc_sequencer_if.slave bus
);

  logic [3:0] ev;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_i  (CLOCK_50),
      .rst_i  (RESET),
      .key_n_i(bus.KEY[k]),
      .press_o(ev[k])
    );
  end

  state_t           state_q, state_d;
  logic [MAG_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [MAG_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             negp_q, negp_d;
  op_t              opp_q, opp_d;
  logic [MAG_W-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic [BCD_W-1:0] dig_q, dig_d;
  logic [3:0]       dig3_q, dig3_d;
  op_t              op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [MAG_W-1:0] opa, opb, acc;
  logic [BCD_W-1:0] bcd_adj, bcd_nx;
  logic             sel_add, sel_sub, sel_mul;

  assign opa = {{(MAG_W-OPND_W){1'b0}}, bus.SW[9:5]};
  assign opb = {{(MAG_W-OPND_W){1'b0}}, bus.SW[4:0]};

  // Priority KEY3 > KEY0 > KEY1 > KEY2, made one-hot for the decoder
  assign sel_add = ev[0] & ~ev[3];
  assign sel_sub = ev[1] & ~ev[0] & ~ev[3];
  assign sel_mul = ev[2] & ~ev[1] & ~ev[0] & ~ev[3];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    negp_d  = negp_q;
    opp_d   = opp_q;
    res_d   = res_q;
    neg_d   = neg_q;
    dig_d   = dig_q;
    dig3_d  = dig3_q;
    op_d    = op_q;
    done_d  = 1'b0;
    acc     = mag_q + (b_q[0] ? a_q : '0);
    bcd_adj = dabble_adj(bcd_q);
    bcd_nx  = {bcd_adj[BCD_W-2:0], sh_q[MAG_W-1]};

    unique case (state_q)
      IDLE, SHOW: begin
        unique case (1'b1)
          sel_add: begin
            mag_d   = opa + opb;
            sh_d    = opa + opb;
            negp_d  = 1'b0;
            opp_d   = OP_ADD;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end
          sel_sub: begin
            mag_d   = (opa < opb) ? opb - opa : opa - opb;
            sh_d    = (opa < opb) ? opb - opa : opa - opb;
            negp_d  = (opa < opb);
            opp_d   = OP_SUB;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end
          sel_mul: begin
            a_d     = opa;
            b_d     = bus.SW[4:0];
            mag_d   = '0;
            negp_d  = 1'b0;
            opp_d   = OP_MUL;
            cnt_d   = '0;
            state_d = MUL;
          end
          default: ;
        endcase
      end
      MUL: begin
        mag_d = acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd4) begin
          sh_d    = acc;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = sh_q << 1;
        bcd_d = bcd_nx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          res_d   = mag_q;
          neg_d   = negp_q;
          dig_d   = bcd_nx;
          dig3_d  = negp_q ? DIG_MINUS : DIG_BLANK;
          op_d    = opp_q;
          done_d  = 1'b1;
          state_d = SHOW;
        end
      end
      default: ;
    endcase

    if (ev[3]) begin
      state_d = IDLE;
      res_d   = '0;
      neg_d   = 1'b0;
      dig_d   = '0;
      dig3_d  = DIG_BLANK;
      op_d    = OP_ADD;
      done_d  = 1'b0;
    end

    busy_d = (state_d == MUL) || (state_d == CONV);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      opp_q   <= OP_ADD;
      res_q   <= '0;
      neg_q   <= 1'b0;
      dig_q   <= '0;
      dig3_q  <= DIG_BLANK;
      op_q    <= OP_ADD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      negp_q  <= negp_d;
      opp_q   <= opp_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      dig_q   <= dig_d;
      dig3_q  <= dig3_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.RESULT = res_q;
  assign bus.NEG    = neg_q;
  assign bus.DIG0   = dig_q[3:0];
  assign bus.DIG1   = dig_q[7:4];
  assign bus.DIG2   = dig_q[11:8];
  assign bus.DIG3   = dig3_q;
  assign bus.OP     = op_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;

  localparam int DEB = 16;
  // key drop -> event: 2 sync + DEB count + 1 edge cycle
  localparam int LAT_AS  = DEB + 13;
  localparam int LAT_MUL = DEB + 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   st[4];

  int         fd, nd, nb;
  logic [9:0] s_res;
  logic [3:0] s_dig3;
  logic       s_busy;

  calc_sequencer_if bus ();

  calc_sequencer #(
    .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // key k is low during steps [st[k], st[k]+hold); RESET high at step rst_at
  task automatic run_keys(input int hold, input int rst_at,
                          input int snap, input int window);
    fd = -1; nd = 0; nb = 0;
    s_res = 'x; s_dig3 = 'x; s_busy = 1'bx;
    for (int n = 0; n < window; n++) begin
      for (int k = 0; k < 4; k++)
        bus.KEY[k] = !(st[k] >= 0 && n >= st[k] && n < st[k] + hold);
      rst = (n == rst_at);
      tick();
      if (bus.DONE) begin
        nd++;
        if (fd < 0) fd = n + 1;
      end
      if (bus.BUSY) nb++;
      if (n + 1 == snap) begin
        s_res = bus.RESULT; s_dig3 = bus.DIG3; s_busy = bus.BUSY;
      end
    end
    bus.KEY = 4'hF;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.SW = '0; bus.KEY = 4'hF; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.RESULT !== 10'd0) begin errors++; $display("FAIL rst_result: got %0d exp 0", bus.RESULT); end
    checks++; if (bus.NEG !== 1'b0) begin errors++; $display("FAIL rst_neg: got %0d exp 0", bus.NEG); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF000) begin errors++; $display("FAIL rst_digs: got %h exp F000", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
    checks++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.OP !== 2'd0) begin errors++; $display("FAIL rst_ctrl: got busy=%0d done=%0d op=%0d exp 0,0,0", bus.BUSY, bus.DONE, bus.OP); end
  endtask

  task automatic test_add_hold();
    bus.SW = {5'd3, 5'd4};
    st = '{0, -1, -1, -1};
    run_keys(DEB + 20, -1, 0, 60);
    checks++; if (fd !== LAT_AS) begin errors++; $display("FAIL add_latency: got %0d exp %0d", fd, LAT_AS); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL add_one_done: got %0d exp 1", nd); end
    checks++; if (bus.RESULT !== 10'd7 || bus.OP !== 2'd0) begin errors++; $display("FAIL add_result: got %0d op %0d exp 7 op 0", bus.RESULT, bus.OP); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF007) begin errors++; $display("FAIL add_digs: got %h exp F007", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
  endtask

  task automatic test_sub();
    bus.SW = {5'd5, 5'd20};
    st = '{-1, 0, -1, -1};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (fd !== LAT_AS) begin errors++; $display("FAIL sub_latency: got %0d exp %0d", fd, LAT_AS); end
    checks++; if (bus.NEG !== 1'b1 || bus.RESULT !== 10'd15) begin errors++; $display("FAIL sub_neg_result: got neg=%0d res=%0d exp 1,15", bus.NEG, bus.RESULT); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hA015) begin errors++; $display("FAIL sub_neg_digs: got %h exp A015", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
    checks++; if (bus.OP !== 2'd1) begin errors++; $display("FAIL sub_op: got %0d exp 1", bus.OP); end
    bus.SW = {5'd20, 5'd5};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (nd !== 1) begin errors++; $display("FAIL sub_pos_done: got %0d exp 1", nd); end
    checks++; if (bus.NEG !== 1'b0 || bus.RESULT !== 10'd15 || bus.DIG3 !== 4'hF) begin errors++; $display("FAIL sub_pos: got neg=%0d res=%0d d3=%h exp 0,15,F", bus.NEG, bus.RESULT, bus.DIG3); end
  endtask

  task automatic test_mul();
    bus.SW = {5'd31, 5'd31};
    st = '{-1, -1, 0, -1};
    run_keys(DEB + 2, -1, DEB + 10, 50);
    checks++; if (fd !== LAT_MUL) begin errors++; $display("FAIL mul_latency: got %0d exp %0d", fd, LAT_MUL); end
    checks++; if (nb !== 15) begin errors++; $display("FAIL mul_busy_cycles: got %0d exp 15", nb); end
    checks++; if (s_res !== 10'd15 || s_busy !== 1'b1) begin errors++; $display("FAIL mul_hold_mid: got res=%0d busy=%0d exp 15,1", s_res, s_busy); end
    checks++; if (bus.RESULT !== 10'd961 || bus.OP !== 2'd2) begin errors++; $display("FAIL mul_result: got %0d op %0d exp 961 op 2", bus.RESULT, bus.OP); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF961) begin errors++; $display("FAIL mul_digs: got %h exp F961", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
  endtask

  task automatic test_boundary();
    bus.SW = {5'd0, 5'd9};
    st = '{-1, -1, 0, -1};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (nd !== 1 || bus.RESULT !== 10'd0 || bus.NEG !== 1'b0) begin errors++; $display("FAIL mul_zero: got done=%0d res=%0d neg=%0d exp 1,0,0", nd, bus.RESULT, bus.NEG); end
    bus.SW = {5'd0, 5'd0};
    st = '{-1, 0, -1, -1};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (nd !== 1 || bus.RESULT !== 10'd0 || bus.DIG3 !== 4'hF || bus.OP !== 2'd1) begin errors++; $display("FAIL sub_zero: got done=%0d res=%0d d3=%h op=%0d exp 1,0,F,1", nd, bus.RESULT, bus.DIG3, bus.OP); end
    bus.SW = {5'd31, 5'd31};
    st = '{0, -1, -1, -1};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (bus.RESULT !== 10'd62 || {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF062) begin errors++; $display("FAIL add_max: got %0d %h exp 62 F062", bus.RESULT, {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
  endtask

  task automatic test_short_and_priority();
    bus.SW = {5'd3, 5'd4};
    st = '{0, -1, -1, -1};
    run_keys(DEB - 1, -1, 0, 40);
    checks++; if (nd !== 0 || nb !== 0 || bus.RESULT !== 10'd62) begin errors++; $display("FAIL short_pulse: got done=%0d busy=%0d res=%0d exp 0,0,62", nd, nb, bus.RESULT); end
    st = '{0, -1, 0, -1};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (fd !== LAT_AS || nd !== 1) begin errors++; $display("FAIL prio_timing: got first=%0d n=%0d exp %0d,1", fd, nd, LAT_AS); end
    checks++; if (bus.RESULT !== 10'd7 || bus.OP !== 2'd0) begin errors++; $display("FAIL prio_add: got %0d op %0d exp 7 op 0", bus.RESULT, bus.OP); end
  endtask

  task automatic test_clear_mul();
    bus.SW = {5'd31, 5'd31};
    st = '{-1, -1, 0, 2};
    run_keys(DEB + 2, -1, 0, 50);
    checks++; if (nd !== 0) begin errors++; $display("FAIL clr_no_done: got %0d exp 0", nd); end
    checks++; if (bus.RESULT !== 10'd0 || bus.BUSY !== 1'b0 || bus.OP !== 2'd0) begin errors++; $display("FAIL clr_state: got res=%0d busy=%0d op=%0d exp 0,0,0", bus.RESULT, bus.BUSY, bus.OP); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF000) begin errors++; $display("FAIL clr_digs: got %h exp F000", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
  endtask

  task automatic test_ignore_conv();
    bus.SW = {5'd6, 5'd7};
    st = '{8, -1, 0, -1};
    run_keys(DEB + 2, -1, 0, 60);
    checks++; if (fd !== LAT_MUL || nd !== 1) begin errors++; $display("FAIL ign_timing: got first=%0d n=%0d exp %0d,1", fd, nd, LAT_MUL); end
    checks++; if (bus.RESULT !== 10'd42 || bus.OP !== 2'd2) begin errors++; $display("FAIL ign_result: got %0d op %0d exp 42 op 2", bus.RESULT, bus.OP); end
    checks++; if ({bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0} !== 16'hF042) begin errors++; $display("FAIL ign_digs: got %h exp F042", {bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0}); end
  endtask

  task automatic test_reset_conv();
    bus.SW = {5'd3, 5'd4};
    st = '{0, -1, -1, -1};
    run_keys(DEB + 2, DEB + 5, DEB + 6, 50);
    checks++; if (s_res !== 10'd0 || s_dig3 !== 4'hF || s_busy !== 1'b0) begin errors++; $display("FAIL rstc_next: got res=%0d d3=%h busy=%0d exp 0,F,0", s_res, s_dig3, s_busy); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rstc_no_done: got %0d exp 0", nd); end
    checks++; if (bus.DIG1 !== 4'd0 || bus.OP !== 2'd0) begin errors++; $display("FAIL rstc_final: got d1=%0d op=%0d exp 0,0", bus.DIG1, bus.OP); end
  endtask

  initial begin
    test_reset();
    test_add_hold();
    test_sub();
    test_mul();
    test_boundary();
    test_short_and_priority();
    test_clear_mul();
    test_ignore_conv();
    test_reset_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
